// File: rtl/sqrt_pkg.sv
// Shared widths, counter limit and FSM encoding for the iterative square root.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
//
// Contents:
//   XW        radicand width (even)
//   YW        root width, XW/2
//   AW        partial remainder width, YW+2
//   CW        iteration counter width
//   CNT_LAST  counter value on the final iteration
//   state_e   LOAD -> CALC -> DONE
package sqrt_pkg;

  localparam int XW = 32;
  localparam int YW = XW / 2;
  localparam int AW = YW + 2;
  localparam int CW = $clog2(YW) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(YW - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sqrt_32_if.sv
// Radicand/result bundle between a requester and the sqrt_32 core.
// Latency: n/a (wires only).
// Backpressure: none; y is meaningful only while rdy is high.
//
// Signals:
//   x    radicand, driven by the master, sampled once per run by the core
//   y    floor(sqrt(x)), driven by the core
//   rdy  high while y holds the final result
interface sqrt_32_if;
  import sqrt_pkg::*;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          rdy;

  modport master (
    output x,
    input  y,
    input  rdy
  );

  modport slave (
    input  x,
    output y,
    output rdy
  );

endinterface

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration (one result bit).
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_acc   partial remainder from the previous iteration
//   i_root  root bits produced so far
//   i_bits  next two radicand bits, MSB pair first
//   o_acc   updated partial remainder
//   o_root  root shifted left with the new bit appended
module sqrt_step
  import sqrt_pkg::*;
(
  input  logic [AW-1:0] i_acc,
  input  logic [YW-1:0] i_root,
  input  logic [1:0]    i_bits,
  output logic [AW-1:0] o_acc,
  output logic [YW-1:0] o_root
);

  logic [AW-1:0] w_a;
  logic [AW-1:0] w_t;
  logic          w_ge;
  logic          w_unused_acc_msbs;

  // Remainder is bounded by 2*root, so while bits are still being brought
  // down the top two acc bits are zero and can be dropped from the shift.
  assign w_a  = {i_acc[AW-3:0], i_bits};
  assign w_t  = {i_root, 2'b01};
  assign w_ge = (w_a >= w_t);

  assign o_acc  = w_ge ? (w_a - w_t) : w_a;
  assign o_root = {i_root[YW-2:0], w_ge};

  assign w_unused_acc_msbs = ^i_acc[AW-1:AW-2];

endmodule

// File: rtl/sqrt_32.sv
// Iterative floor(sqrt(x)) for 32-bit unsigned x, one root bit per clock.
// Latency: rdy rises on the 17th rising edge after reset release (1 load + 16 steps).
// Backpressure: none; runs once per reset release, then holds the result forever.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; release starts a run
//   bus    sqrt_32_if.slave: x in, y/rdy out
module sqrt_32
  import sqrt_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  sqrt_32_if.slave bus
);

  // Radicand, partial remainder, root-in-progress and iteration count.
  logic [XW-1:0] rad;
  logic [AW-1:0] acc;
  logic [YW-1:0] root;
  logic [CW-1:0] cnt;
  state_e        state;

  logic [YW-1:0] r_y;
  logic          r_rdy;

  logic [AW-1:0] w_acc_nxt;
  logic [YW-1:0] w_root_nxt;

  sqrt_step u_step (
    .i_acc  (acc),
    .i_root (root),
    .i_bits (rad[XW-1:XW-2]),
    .o_acc  (w_acc_nxt),
    .o_root (w_root_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rad   <= '0;
      acc   <= '0;
      root  <= '0;
      cnt   <= '0;
      r_y   <= '0;
      r_rdy <= 1'b0;
      state <= LOAD;
    end else begin
      case (state)
        LOAD: begin
          // Only sample point for x in a run.
          rad   <= bus.x;
          acc   <= '0;
          root  <= '0;
          cnt   <= '0;
          state <= CALC;
        end
        CALC: begin
          acc  <= w_acc_nxt;
          root <= w_root_nxt;
          rad  <= {rad[XW-3:0], 2'b00};
          cnt  <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            r_y   <= w_root_nxt;
            r_rdy <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // Hold result and remainder until the next reset.
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  assign bus.y   = r_y;
  assign bus.rdy = r_rdy;

endmodule

// File: tb/tb_sqrt_32.sv
module tb_sqrt_32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  sqrt_32_if bus ();

  sqrt_32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts 17 edges from a reset release, checking rdy/y timing.
  // Optionally changes x right after edge chg_edge (0 = never).
  task automatic run17(input string tag, input int chg_edge, input logic [31:0] chg_x);
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk);
      #1;
      if (e == chg_edge) bus.x = chg_x;
      if (e == 16) begin
        chk({tag, "_rdy16"}, {63'd0, bus.rdy}, 64'd0);
        chk({tag, "_y16"}, {48'd0, bus.y}, 64'd0);
      end
      if (e == 17) chk({tag, "_rdy17"}, {63'd0, bus.rdy}, 64'd1);
    end
  endtask

  task automatic start(input logic [31:0] xv);
    reset = 1'b0;
    bus.x = xv;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic vec(input string tag, input logic [31:0] xv,
                     input logic [15:0] ey, input logic [17:0] ea);
    start(xv);
    run17(tag, 0, 32'd0);
    chk({tag, "_y"}, {48'd0, bus.y}, {48'd0, ey});
    chk({tag, "_acc"}, {46'd0, dut.acc}, {46'd0, ea});
  endtask

  initial begin
    logic [31:0] xr;
    logic [63:0] yy;
    logic [63:0] yy1;
    logic [63:0] yv;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.x = 32'd63;

    #42;
    chk("rst_rdy", {63'd0, bus.rdy}, 64'd0);
    chk("rst_y", {48'd0, bus.y}, 64'd0);
    chk("rst_acc", {46'd0, dut.acc}, 64'd0);
    chk("rst_root", {48'd0, dut.root}, 64'd0);
    chk("rst_rad", {32'd0, dut.rad}, 64'd0);
    chk("rst_cnt", {59'd0, dut.cnt}, 64'd0);
    #58;
    reset = 1'b1;   // release at t=100
    run17("x63", 0, 32'd0);
    chk("x63_y", {48'd0, bus.y}, 64'd7);
    chk("x63_acc", {46'd0, dut.acc}, 64'd14);

    // DONE holds regardless of x and time.
    bus.x = 32'd0;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_y", {48'd0, bus.y}, 64'd7);
    chk("hold_rdy", {63'd0, bus.rdy}, 64'd1);
    chk("hold_acc", {46'd0, dut.acc}, 64'd14);

    vec("x0", 32'd0, 16'd0, 18'd0);
    vec("x1", 32'd1, 16'd1, 18'd0);
    vec("x2", 32'd2, 16'd1, 18'd1);
    vec("x15", 32'd15, 16'd3, 18'd6);
    vec("x16", 32'd16, 16'd4, 18'd0);
    vec("x24", 32'd24, 16'd4, 18'd8);
    vec("x64", 32'd64, 16'd8, 18'd0);
    vec("x99", 32'd99, 16'd9, 18'd18);
    vec("x65535", 32'd65535, 16'd255, 18'd510);
    vec("x1e6", 32'd1000000, 16'd1000, 18'd0);
    vec("xmax", 32'hFFFF_FFFF, 16'hFFFF, 18'h1FFFE);
    vec("xsq_max", 32'hFFFE_0001, 16'hFFFF, 18'd0);
    vec("xfffe", 32'hFFFE_0000, 16'hFFFE, 18'h1FFFC);
    vec("x4000", 32'h4000_0000, 16'h8000, 18'd0);

    // x changes mid-CALC must be ignored.
    start(32'd63);
    run17("xchg", 5, 32'hFFFF_FFFF);
    chk("xchg_y", {48'd0, bus.y}, 64'd7);
    chk("xchg_acc", {46'd0, dut.acc}, 64'd14);

    // Reset asserted just after the 8th CALC edge aborts immediately.
    start(32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1;
    chk("abort_cnt8", {59'd0, dut.cnt}, 64'd8);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_rdy", {63'd0, bus.rdy}, 64'd0);
    chk("abort_y", {48'd0, bus.y}, 64'd0);
    chk("abort_acc", {46'd0, dut.acc}, 64'd0);
    chk("abort_cnt", {59'd0, dut.cnt}, 64'd0);
    bus.x = 32'd100;
    @(negedge clk);
    reset = 1'b1;
    run17("x100", 0, 32'd0);
    chk("x100_y", {48'd0, bus.y}, 64'd10);
    chk("x100_acc", {46'd0, dut.acc}, 64'd0);

    // Random sweep checked against the defining inequality.
    for (int i = 0; i < 1000; i++) begin
      xr = $urandom();
      start(xr);
      run17("rnd", 0, 32'd0);
      yv  = {48'd0, bus.y};
      yy  = yv * yv;
      yy1 = (yv + 64'd1) * (yv + 64'd1);
      chk("rnd_lo", {63'd0, yy <= {32'd0, xr}}, 64'd1);
      chk("rnd_hi", {63'd0, {32'd0, xr} < yy1}, 64'd1);
      chk("rnd_acc", {46'd0, dut.acc}, {32'd0, xr} - yy);
      chk("rnd_accbnd", {63'd0, {46'd0, dut.acc} <= 64'd2 * yv}, 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
